// File: rtl/ysyx_24100012_inst_fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package ysyx_24100012_inst_fetch_pkg;

    localparam int unsigned XLEN               = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 2;

    // Fetch FSM: FETCH issues, WAIT expects a live response, DROP discards a stale one.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_e;

    // One buffered instruction and the address it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_24100012_inst_fetch_if.sv
// Redirect, instruction-memory and decode-side signals of the fetch unit.
interface ysyx_24100012_inst_fetch_if;
    import ysyx_24100012_inst_fetch_pkg::*;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;

    // Fetch unit side.
    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_ready,
        output imem_req_valid, imem_req_addr,
        output inst_valid, inst, inst_pc
    );

    // Memory / decode / branch-resolution side.
    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_ready,
        input  imem_req_valid, imem_req_addr,
        input  inst_valid, inst, inst_pc
    );

endinterface

// File: rtl/ysyx_24100012_fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, inst} entries with a single-cycle flush.
module ysyx_24100012_fetch_fifo
    import ysyx_24100012_inst_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t wdata,
    input  logic         pop,
    output fetch_entry_t rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_ok_c;
    logic             push_ok_c;

    // A pop frees a slot in the same cycle, so push on full is allowed alongside a pop.
    assign pop_ok_c  = pop && !empty;
    assign push_ok_c = push && (!full || pop_ok_c);

    // Storage, pointers (wrap modulo DEPTH) and occupancy; flush empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_c) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/ysyx_24100012_inst_fetch.sv
// Instruction fetch: owns the PC, keeps one read outstanding, buffers words toward decode.
module ysyx_24100012_inst_fetch
    import ysyx_24100012_inst_fetch_pkg::*;
#(
    parameter int unsigned     DATA_WIDTH = XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned     FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    ysyx_24100012_inst_fetch_if.master  bus
);

    fetch_state_e          state_q;
    fetch_state_e          state_d;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_d;
    logic                  run_q;
    logic                  req_valid_c;
    logic                  req_fire_c;
    logic                  push_c;
    logic                  fifo_full;
    logic                  fifo_empty;
    fetch_entry_t          push_entry_c;
    fetch_entry_t          head;

    // Requests only while idle, out of reset, and with room for the returning word.
    assign req_valid_c = run_q && (state_q == ST_FETCH) && !fifo_full;
    assign req_fire_c  = req_valid_c && bus.imem_req_ready;

    // In WAIT the PC has already advanced past the outstanding request.
    assign push_entry_c = '{pc: pc_q - DATA_WIDTH'(4), inst: bus.imem_rsp_data};

    // State, PC and the post-reset request enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            run_q   <= 1'b1;
        end
    end

    // Next state, next PC and FIFO push; a redirect overrides everything else.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push_c  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (req_fire_c) begin
                    state_d = bus.redirect_valid ? ST_DROP : ST_WAIT;
                    pc_d    = pc_q + DATA_WIDTH'(4);
                end
            end
            ST_WAIT: begin
                if (bus.redirect_valid) begin
                    state_d = bus.imem_rsp_valid ? ST_FETCH : ST_DROP;
                end else if (bus.imem_rsp_valid) begin
                    state_d = ST_FETCH;
                    push_c  = 1'b1;
                end
            end
            ST_DROP: begin
                // The stale response retires DROP even if another redirect lands with it.
                if (bus.imem_rsp_valid) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
        if (bus.redirect_valid) begin
            pc_d = align_word(bus.redirect_pc);
        end
    end

    ysyx_24100012_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.redirect_valid),
        .push  (push_c),
        .wdata (push_entry_c),
        .pop   (bus.inst_ready),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.imem_req_valid = req_valid_c;
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = !fifo_empty;
    assign bus.inst           = head.inst;
    assign bus.inst_pc        = head.pc;

endmodule

// File: tb/tb_ysyx_24100012_inst_fetch.sv
// Bench for the fetch unit: memory model, transaction-level reference, directed and random traffic.
module tb_ysyx_24100012_inst_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic clk;
    logic rst_n;

    ysyx_24100012_inst_fetch_if bus ();

    ysyx_24100012_inst_fetch #(
        .RESET_PC (RST_PC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference: expected buffer contents, the next fetch address and the one in-flight read.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] w;
    } exp_t;

    exp_t        mq[$];
    bit          outstanding;
    bit          stale;
    bit          released;
    logic [31:0] out_addr;
    logic [31:0] fetch_pc;
    int          out_delay;
    int          delivered;

    typedef struct {
        bit          rr;
        bit          ir;
        int          dly;
        bit          e_rv;
        logic [31:0] e_addr;
        bit          e_iv;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[8];

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        nvec++;
        nerr++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        outstanding = 1'b0;
        stale       = 1'b0;
        released    = 1'b0;
        fetch_pc    = RST_PC;
        out_delay   = 0;
        out_addr    = '0;
    endtask

    // One cycle, entered and left at a falling edge: check outputs, drive inputs, advance model.
    task automatic tick(input bit rr, input bit ir, input bit redir,
                        input logic [31:0] rpc, input int dly);
        bit rsp;
        bit exp_rv;
        bit exp_iv;
        bit acc;
        bit pop;
        rsp    = outstanding && (out_delay == 0);
        exp_rv = released && !outstanding && (mq.size() < 2);
        exp_iv = (mq.size() != 0);
        chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("req_addr", bus.imem_req_addr, fetch_pc);
        chk("inst_valid", 32'(bus.inst_valid), 32'(exp_iv));
        if (exp_iv) begin
            chk("inst_pc", bus.inst_pc, mq[0].pc);
            chk("inst", bus.inst, mq[0].w);
        end
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? word(out_addr) : $urandom();
        bus.imem_req_ready = rr;
        bus.inst_ready     = ir;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        acc = exp_rv && rr;
        pop = exp_iv && ir;
        @(posedge clk);
        if (pop) begin
            void'(mq.pop_front());
            delivered++;
        end
        if (rsp) begin
            if (!stale && !redir) mq.push_back('{out_addr, word(out_addr)});
            outstanding = 1'b0;
            stale       = 1'b0;
        end else if (outstanding) begin
            out_delay--;
            if (redir) stale = 1'b1;
        end
        if (acc) begin
            outstanding = 1'b1;
            out_addr    = fetch_pc;
            out_delay   = dly;
            stale       = redir;
            fetch_pc    = fetch_pc + 32'd4;
        end
        if (redir) begin
            mq.delete();
            fetch_pc = {rpc[31:2], 2'b00};
        end
        released = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (released && !outstanding && mq.size() == 0) done = 1'b1;
            else tick(1'b0, 1'b1, 1'b0, 32'h0, 0);
        end
        if (!done) timeout("wait_idle");
    endtask

    task automatic wait_req(input string name, input logic [31:0] exp_addr);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            if (bus.imem_req_valid) done = 1'b1;
            else tick(1'b0, 1'b1, 1'b0, 32'h0, 0);
        end
        if (done) chk(name, bus.imem_req_addr, exp_addr);
        else timeout(name);
    endtask

    task automatic wait_inst(input string name, input logic [31:0] exp_pc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            if (bus.inst_valid) done = 1'b1;
            else tick(1'b1, 1'b0, 1'b0, 32'h0, 0);
        end
        if (done) chk(name, bus.inst_pc, exp_pc);
        else timeout(name);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'h0);
        chk({tag, "_inst_valid"}, 32'(bus.inst_valid), 32'h0);
        chk({tag, "_inst"}, bus.inst, 32'h0);
        chk({tag, "_inst_pc"}, bus.inst_pc, 32'h0);
    endtask

    task automatic drive_idle();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b0;
    endtask

    initial begin
        // Straight-line fetch from reset with a 1-cycle memory and decode always ready.
        tbl[0] = '{1'b1, 1'b1, 0, 1'b0, 32'h0,         1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 0, 1'b1, 32'h8000_0000, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 0, 1'b0, 32'h0,         1'b0, 32'h0};
        tbl[3] = '{1'b1, 1'b1, 0, 1'b1, 32'h8000_0004, 1'b1, 32'h8000_0000};
        tbl[4] = '{1'b1, 1'b1, 0, 1'b0, 32'h0,         1'b0, 32'h0};
        tbl[5] = '{1'b1, 1'b1, 0, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0004};
        tbl[6] = '{1'b1, 1'b1, 0, 1'b0, 32'h0,         1'b0, 32'h0};
        tbl[7] = '{1'b1, 1'b1, 0, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0008};

        delivered = 0;
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tbl%0d_req_valid", i), 32'(bus.imem_req_valid), 32'(tbl[i].e_rv));
            if (tbl[i].e_rv) chk($sformatf("tbl%0d_req_addr", i), bus.imem_req_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_inst_valid", i), 32'(bus.inst_valid), 32'(tbl[i].e_iv));
            if (tbl[i].e_iv) begin
                chk($sformatf("tbl%0d_inst_pc", i), bus.inst_pc, tbl[i].e_pc);
                chk($sformatf("tbl%0d_inst", i), bus.inst, word(tbl[i].e_pc));
            end
            tick(tbl[i].rr, tbl[i].ir, 1'b0, 32'h0, tbl[i].dly);
        end

        // Decode stalls: buffer fills to two, requests stop, head held.
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0, 32'h0, 0);
        chk("stall_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("stall_inst_valid", 32'(bus.inst_valid), 32'h1);
        chk("stall_head_pc", bus.inst_pc, 32'h8000_000C);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b0, 32'h0, 0);

        // Redirect while a slow read is outstanding: late response is discarded.
        wait_idle();
        tick(1'b1, 1'b1, 1'b0, 32'h0, 3);
        tick(1'b0, 1'b1, 1'b1, 32'h8000_0103, 0);
        chk("wait_redir_inst_valid", 32'(bus.inst_valid), 32'h0);
        wait_req("wait_redir_addr", 32'h8000_0100);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b0, 32'h0, 0);

        // Redirect coinciding with a response and a pop.
        wait_idle();
        tick(1'b1, 1'b0, 1'b0, 32'h0, 0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 0);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 0);
        tick(1'b0, 1'b1, 1'b1, 32'h8000_2000, 0);
        chk("redir_pop_inst_valid", 32'(bus.inst_valid), 32'h0);
        wait_inst("redir_pop_target_pc", 32'h8000_2000);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 1'b0, 32'h0, 1);

        // Random ready/latency/redirect traffic against the reference.
        for (int i = 0; i < 2500; i++) begin
            tick(($urandom % 3) != 0, ($urandom % 4) != 0, ($urandom % 50) == 0,
                 $urandom(), int'($urandom_range(0, 5)));
        end

        // Asynchronous reset in the middle of an outstanding read.
        wait_idle();
        tick(1'b1, 1'b0, 1'b0, 32'h0, 0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 0);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 5);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 0);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("async_rst");
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_req("post_rst_addr", RST_PC);
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, 1'b0, 32'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
